// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_OFF  = 1'b1;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment lookup.
// Output is registered by the instantiating scan driver.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display scanner with inter-digit blanking.
// Optional SEG7_LEADING_ZERO_SUPPRESS_EN blanks leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 2
)
(
    input  logic                  I_CLK,
    input  logic                  rst,
    input  logic                  scan_tick,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [7:0] BC = 8'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = {DIGITS{AN_OFF}};

    state_e          state;
    state_e          state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nxt;
    logic            tick_q;
    logic            tick_edge;
    logic            enter_show;
    logic [3:0]      nib [DIGITS];
    logic [3:0]      cur_nib;
    logic [6:0]      cur_seg;
    logic [DIGITS-1:0] blank_eff;

    assign tick_edge = scan_tick & ~tick_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
        assign nib[k] = data[4*k +: 4];
    end

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    logic [DIGITS-1:0] lz;

    // lz[k]: every nibble from k upward is zero; digit 0 never suppressed
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (nib[DIGITS-1] == 4'h0);
        for (int k = DIGITS - 2; k > 0; k--) begin
            lz[k] = lz[k+1] & (nib[k] == 4'h0);
        end
    end

    assign blank_eff = blank | lz;
`else
    assign blank_eff = blank;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (tick_edge) begin
                    cnt_nxt   = BC;
                    state_nxt = (BC == 8'd0) ? SHOW : BLANK;
                end
            end
            BLANK: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (tick_edge) begin
                    idx_nxt   = (idx == LAST) ? '0 : idx + 1'b1;
                    cnt_nxt   = BC;
                    state_nxt = (BC == 8'd0) ? SHOW : BLANK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SHOW re-entered from SHOW only on a zero-length blank interval
    assign enter_show = (state_nxt == SHOW)
                      && ((state != SHOW) || tick_edge);

    assign cur_nib = nib[idx_nxt];

    hex_to_seg7 u_dec (
        .hex (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            tick_q      <= 1'b0;
            an          <= AN_ALL_OFF;
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            tick_q      <= scan_tick;
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            frame_start <= enter_show && (idx_nxt == '0);
            if (enter_show) begin
                if (blank_eff[idx_nxt]) begin
                    an   <= AN_ALL_OFF;
                    seg  <= SEG_OFF;
                    dp_n <= 1'b1;
                end else begin
                    an   <= ~(DIGITS'(1) << idx_nxt);
                    seg  <= cur_seg;
                    dp_n <= ~dp[idx_nxt];
                end
            end else if (state_nxt != SHOW) begin
                an   <= AN_ALL_OFF;
                seg  <= SEG_OFF;
                dp_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, BLANK_CYCLES=2).
// Also exercises SEG7_LEADING_ZERO_SUPPRESS_EN when defined.
module tb_seg7_scan_driver;

    logic        I_CLK = 1'b0;
    logic        rst;
    logic        scan_tick;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    always #5 I_CLK = ~I_CLK;

    seg7_scan_driver #(
        .DIGITS       (4),
        .BLANK_CYCLES (2)
    ) dut (
        .I_CLK       (I_CLK),
        .rst         (rst),
        .scan_tick   (scan_tick),
        .data        (data),
        .dp          (dp),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        exp_t        e;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(
        input logic [3:0] a,
        input logic [6:0] s,
        input logic       d,
        input logic       f
    );
        exp_t e;
        e.an   = a;
        e.seg  = s;
        e.dp_n = d;
        e.fs   = f;
        return e;
    endfunction

    function automatic vec_t mv(
        input logic [15:0] d,
        input logic [3:0]  p,
        input logic [3:0]  b,
        input exp_t        e
    );
        vec_t v;
        v.data  = d;
        v.dp    = p;
        v.blank = b;
        v.e     = e;
        return v;
    endfunction

    function automatic void chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    task automatic chk_out(input string tag, input exp_t e, input logic fs);
        chk({tag, " an"},   32'(an),          32'(e.an));
        chk({tag, " seg"},  32'(seg),         32'(e.seg));
        chk({tag, " dp_n"}, 32'(dp_n),        32'(e.dp_n));
        chk({tag, " fs"},   32'(frame_start), 32'(fs));
    endtask

    exp_t OFF;

    // One scan slot: rise at start, pat[c] driven after check c.
    task automatic slot(
        input exp_t        e,
        input int          per,
        input logic [31:0] pat,
        input logic [15:0] mid,
        input string       tag
    );
        exp_t cur;
        cur = OFF;
        scan_tick = 1'b1;
        sb.push_back(e);
        for (int c = 0; c < per; c++) begin
            @(negedge I_CLK);
            if (c < 2) begin
                chk_out({tag, " gap"}, OFF, 1'b0);
            end else begin
                if (c == 2) cur = sb.pop_front();
                chk_out({tag, " show"}, cur, (c == 2) ? cur.fs : 1'b0);
            end
            scan_tick = pat[c];
            if (c == 3) data = mid;
        end
    endtask

    initial begin
        OFF = mk(4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        scan_tick = 1'b0;
        data = '0;
        dp = '0;
        blank = '0;
        repeat (2) @(negedge I_CLK);
        chk_out("reset", OFF, 1'b0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge I_CLK);
            chk_out("idle", OFF, 1'b0);
        end

        for (int f = 0; f < 2; f++) begin
            vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0000, mk(4'hE, 7'h0E, 1'b1, 1'b1)));
            vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0000, mk(4'hD, 7'h24, 1'b1, 1'b0)));
            vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0000, mk(4'hB, 7'h08, 1'b0, 1'b0)));
            vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0000, mk(4'h7, 7'h79, 1'b1, 1'b0)));
        end
        vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0010, mk(4'hE, 7'h0E, 1'b1, 1'b1)));
        vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0010, OFF));
        vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0010, mk(4'hB, 7'h08, 1'b0, 1'b0)));
        vecs.push_back(mv(16'h1A2F, 4'b0100, 4'b0010, mk(4'h7, 7'h79, 1'b1, 1'b0)));
        vecs.push_back(mv(16'hB3E0, 4'b0001, 4'b0000, mk(4'hE, 7'h40, 1'b0, 1'b1)));
        vecs.push_back(mv(16'hB3E0, 4'b0001, 4'b0000, mk(4'hD, 7'h06, 1'b1, 1'b0)));
        vecs.push_back(mv(16'hB3E0, 4'b0001, 4'b0000, mk(4'hB, 7'h30, 1'b1, 1'b0)));
        vecs.push_back(mv(16'hB3E0, 4'b0001, 4'b0000, mk(4'h7, 7'h03, 1'b1, 1'b0)));
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
        vecs.push_back(mv(16'h0070, 4'b0000, 4'b0000, mk(4'hE, 7'h40, 1'b1, 1'b1)));
        vecs.push_back(mv(16'h0070, 4'b0000, 4'b0000, mk(4'hD, 7'h78, 1'b1, 1'b0)));
        vecs.push_back(mv(16'h0070, 4'b0000, 4'b0000, OFF));
        vecs.push_back(mv(16'h0070, 4'b0000, 4'b0000, OFF));
        vecs.push_back(mv(16'h0000, 4'b0000, 4'b0000, mk(4'hE, 7'h40, 1'b1, 1'b1)));
        vecs.push_back(mv(16'h0000, 4'b0000, 4'b0000, OFF));
        vecs.push_back(mv(16'h0000, 4'b0000, 4'b0000, OFF));
        vecs.push_back(mv(16'h0000, 4'b0000, 4'b0000, OFF));
`endif

        foreach (vecs[i]) begin
            data  = vecs[i].data;
            dp    = vecs[i].dp;
            blank = vecs[i].blank;
            slot(vecs[i].e, 10, 32'hF, vecs[i].data, $sformatf("vec%0d", i));
        end

        data  = 16'h1A2F;
        dp    = 4'b0100;
        blank = 4'b0000;
        slot(mk(4'hE, 7'h0E, 1'b1, 1'b1), 10, 32'hF, 16'h1A27, "hold");
        slot(mk(4'hD, 7'h24, 1'b1, 1'b0), 10, 32'hF, 16'h1A27, "next");
        slot(mk(4'hB, 7'h08, 1'b0, 1'b0), 12, 32'h7F, 16'h1A27, "long_high");
        slot(mk(4'h7, 7'h79, 1'b1, 1'b0), 12, 32'h3E, 16'h1A27, "glitch");
        slot(mk(4'hE, 7'h78, 1'b1, 1'b1), 10, 32'hF, 16'h1A27, "one_adv");
        slot(mk(4'hD, 7'h24, 1'b1, 1'b0), 10, 32'hF, 16'h1A27, "pre_rst");

        scan_tick = 1'b1;
        repeat (3) @(negedge I_CLK);
        chk_out("rst_lit", mk(4'hB, 7'h08, 1'b0, 1'b0), 1'b0);
        rst = 1'b1;
        scan_tick = 1'b0;
        @(negedge I_CLK);
        chk_out("rst_abort", OFF, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge I_CLK);
            chk_out("rst_idle", OFF, 1'b0);
        end
        slot(mk(4'hE, 7'h78, 1'b1, 1'b1), 10, 32'hF, 16'h1A27, "post_rst");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
